reg_file_32x64: RTL and testbench
=================================

Name: reg_file_32x64

Overview:
- Architectural register file for the ARM 64-bit datapath: 32 entries of N bits, two read ports (Rn, Rm/Rt), one write port, plus the NZCV flag register.
- Sits in the decode stage. Its read data feeds the ALU-input and write-back selection muxes. Write data comes from the write-back stage.
- Entry 31 is XZR: it always reads 0 and writes to it are discarded.
- Includes write-to-read bypass, so an instruction reading a register in the same cycle it is written sees the new value.

Parameters:
- N, 64, data width of each register.
- ZERO_REG, 31, index hardwired to zero (XZR).
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return the pre-write value.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ReadReg1  in  5  index for read port 1 (Rn).
- ReadReg2  in  5  index for read port 2 (Rm/Rt).
- ReadData1  out  N  combinational read data, port 1.
- ReadData2  out  N  combinational read data, port 2.
- RegWrite  in  1  write enable.
- WriteReg  in  5  write index (Rd).
- WriteData  in  N  write data.
- FlagWrite  in  1  NZCV update enable (S-suffixed instructions).
- FlagsIn  in  4  {N,Z,C,V} from the ALU.
- FlagsOut  out  4  current NZCV.

Behaviour:
- Clock and reset: single clock, clk. reset is synchronous and active-high: sampled on the rising edge of clk only.
- Reset effect: while reset=1 at a rising edge, all 32 entries and NZCV clear to 0. RegWrite and FlagWrite are ignored on that edge. After the reset edge, ReadData1/2=0 for any index and FlagsOut=4'b0000.
- Reset mid-operation: a write asserted in the same cycle as reset is lost. The first write that takes effect is the one asserted on the first edge with reset=0.
- Write: on rising edge with reset=0, RegWrite=1 and WriteReg!=ZERO_REG, entry[WriteReg] <= WriteData. If WriteReg==ZERO_REG, no state changes.
- Read: ReadDataK is a combinational function of ReadRegK and the stored entries, with zero cycles of latency.
  - ReadRegK==ZERO_REG returns all-zero, regardless of any pending write.
  - If BYPASS=1, RegWrite=1, WriteReg==ReadRegK and ReadRegK!=ZERO_REG, ReadDataK=WriteData in the same cycle, before the edge.
  - If BYPASS=1 and reset=1, no bypass; the port returns the stored value.
  - Otherwise ReadDataK=entry[ReadRegK].
- Both ports may address the same register. Each port resolves independently, including bypass.
- Flags: on rising edge with reset=0 and FlagWrite=1, NZCV <= FlagsIn. FlagsOut is registered only (no bypass), so the new flags appear one cycle after the update. FlagWrite and RegWrite are independent and may coincide.
- No X propagation: every stored bit has a defined reset value, and the indices are fully decoded (32 of 32).

Decomposition:
- Shared package (cpu_defs):
  - REG_IDX_W=5, NUM_REGS=32, XZR_IDX=31.
  - Flag bit positions FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One natural sub-module, reg_read_port: a 32:1 N-bit select plus zero-register and bypass override. It is instantiated twice, once per read port.
- The write decoder and storage stay in the top module.

Test Plan:
- Reset: assert reset 1 cycle after random writes -> ReadData1/2=0 for all 32 indices and FlagsOut=0000. A write with WriteReg=5 and WriteData=64'hDEAD issued together with reset -> X5 reads 0 afterwards.
- Basic write/read: write X3=64'h0123_4567_89AB_CDEF, then X4=64'hFFFF_FFFF_FFFF_FFFF. Set ReadReg1=3, ReadReg2=4 -> outputs match both values. X3 stays unchanged after the X4 write.
- XZR: RegWrite=1, WriteReg=31, WriteData=64'h1 -> ReadData1 with ReadReg1=31 is 0 both before and after the edge. No other entry changes.
- Bypass: X7 holds 64'hAA. Drive RegWrite=1, WriteReg=7, WriteData=64'h55, ReadReg1=ReadReg2=7 -> both ports give 64'h55 in that same cycle (BYPASS=1). With BYPASS=0 both give 64'hAA until the edge, then 64'h55.
- Flags: FlagWrite=1, FlagsIn=1010 -> FlagsOut=1010 one cycle later. FlagWrite=0, FlagsIn=0101 -> FlagsOut holds 1010. A simultaneous RegWrite to X9 and FlagWrite both take effect.
- Sweep: write Xi = i*64'h0101_0101_0101_0101 for i=0..30, then read all pairs (i, 30-i) -> all values match. X31 reads 0.

Source files
------------

// File: rtl/reg_file_32x64_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_32x64_pkg
// Shared definitions for the architectural register file: index width, entry
// count, the XZR index and the NZCV flag bit positions.
// ----------------------------------------------------------------------------
package reg_file_32x64_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;
   localparam int XZR_IDX   = 31;

   // Bit positions inside the 4-bit {N,Z,C,V} flag vector.
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [3:0]           nzcv_t;

endpackage

// File: rtl/reg_file_32x64_if.sv
// ----------------------------------------------------------------------------
// reg_file_32x64_if
// Decode-stage access bundle for the register file.
//   ReadReg1/ReadReg2   : read indices (Rn, Rm/Rt)
//   ReadData1/ReadData2 : combinational read data
//   RegWrite/WriteReg/WriteData : write port from write-back
//   FlagWrite/FlagsIn   : NZCV update from the ALU
//   FlagsOut            : current NZCV
// master = pipeline side, slave = register file side.
// ----------------------------------------------------------------------------
interface reg_file_32x64_if
   import reg_file_32x64_pkg::*;
#(
   parameter int N = 64
);

   reg_idx_t       ReadReg1;
   reg_idx_t       ReadReg2;
   logic [N-1:0]   ReadData1;
   logic [N-1:0]   ReadData2;
   logic           RegWrite;
   reg_idx_t       WriteReg;
   logic [N-1:0]   WriteData;
   logic           FlagWrite;
   nzcv_t          FlagsIn;
   nzcv_t          FlagsOut;

   modport master (
      output ReadReg1, ReadReg2, RegWrite, WriteReg, WriteData, FlagWrite, FlagsIn,
      input  ReadData1, ReadData2, FlagsOut
   );

   modport slave (
      input  ReadReg1, ReadReg2, RegWrite, WriteReg, WriteData, FlagWrite, FlagsIn,
      output ReadData1, ReadData2, FlagsOut
   );

endinterface

// File: rtl/reg_file_32x64_read_port.sv
// ----------------------------------------------------------------------------
// reg_read_port
// One combinational read port: 32:1 N-bit select with XZR override and
// optional same-cycle write-to-read forwarding.
//   regs     : stored entries
//   idx      : read index
//   reset    : synchronous reset in flight (suppresses forwarding)
//   wr_en    : write enable of the write port
//   wr_idx   : write index
//   wr_data  : write data
//   rd_data  : resolved read data
// ----------------------------------------------------------------------------
module reg_read_port
   import reg_file_32x64_pkg::*;
#(
   parameter int N        = 64,
   parameter int ZERO_REG = XZR_IDX,
   parameter bit BYPASS   = 1'b1
) (
   input  logic [N-1:0] regs [NUM_REGS],
   input  reg_idx_t     idx,
   input  logic         reset,
   input  logic         wr_en,
   input  reg_idx_t     wr_idx,
   input  logic [N-1:0] wr_data,
   output logic [N-1:0] rd_data
);

   localparam reg_idx_t ZIDX = REG_IDX_W'(ZERO_REG);

   logic fwd;

   // A write landing in reset is discarded, so it must not be forwarded either.
   assign fwd = BYPASS && !reset && wr_en && (wr_idx == idx);

   always_comb begin
      // NOTE: default assignment first so every path drives rd_data and no latch is inferred.
      rd_data = regs[idx];
      if (idx == ZIDX) begin
         rd_data = '0;
      end else if (fwd) begin
         rd_data = wr_data;
      end
   end

endmodule

// File: rtl/reg_file_32x64.sv
// ----------------------------------------------------------------------------
// reg_file_32x64
// Architectural register file: 32 x N entries (entry ZERO_REG is XZR), two
// combinational read ports with optional write-to-read bypass, one write
// port, and the registered NZCV flag register.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears all entries and NZCV
//   rf    : access bundle (slave side), see reg_file_32x64_if
// ----------------------------------------------------------------------------
module reg_file_32x64
   import reg_file_32x64_pkg::*;
#(
   parameter int N        = 64,
   parameter int ZERO_REG = XZR_IDX,
   parameter bit BYPASS   = 1'b1
) (
   input logic             clk,
   input logic             reset,
   reg_file_32x64_if.slave rf
);

   localparam reg_idx_t ZIDX = REG_IDX_W'(ZERO_REG);

   logic [N-1:0] regs [NUM_REGS];
   nzcv_t        nzcv;

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the storage is plain flops, so every entry is cleared explicitly to keep X out of reads.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         nzcv <= '0;
      end else begin
         if (rf.RegWrite && (rf.WriteReg != ZIDX)) begin
            regs[rf.WriteReg] <= rf.WriteData;
         end
         if (rf.FlagWrite) begin
            nzcv <= rf.FlagsIn;
         end
      end
   end

   // Flags are never forwarded: an update is visible one cycle later.
   assign rf.FlagsOut = nzcv;

   reg_read_port #(
      .N        (N),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_port1 (
      .regs    (regs),
      .idx     (rf.ReadReg1),
      .reset   (reset),
      .wr_en   (rf.RegWrite),
      .wr_idx  (rf.WriteReg),
      .wr_data (rf.WriteData),
      .rd_data (rf.ReadData1)
   );

   reg_read_port #(
      .N        (N),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_port2 (
      .regs    (regs),
      .idx     (rf.ReadReg2),
      .reset   (reset),
      .wr_en   (rf.RegWrite),
      .wr_idx  (rf.WriteReg),
      .wr_data (rf.WriteData),
      .rd_data (rf.ReadData2)
   );

endmodule

// File: tb/tb_reg_file_32x64.sv
// ----------------------------------------------------------------------------
// tb_reg_file_32x64
// Drives two register files side by side (forwarding on / off) with the same
// directed vectors. Each vector pushes its expected outputs into a queue; a
// monitor on the falling edge pops and compares them against the DUTs.
// ----------------------------------------------------------------------------
module tb_reg_file_32x64;
   import reg_file_32x64_pkg::*;

   localparam int N = 64;

   typedef enum int {SEL_RD1_A, SEL_RD2_A, SEL_FL_A, SEL_RD1_B, SEL_RD2_B, SEL_FL_B} sel_e;

   typedef struct {
      string       name;
      sel_e        sel;
      logic [63:0] exp;
   } exp_t;

   logic clk;
   logic reset;

   reg_file_32x64_if #(.N(N)) rf_a ();
   reg_file_32x64_if #(.N(N)) rf_b ();

   reg_file_32x64 #(.N(N), .ZERO_REG(XZR_IDX), .BYPASS(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .rf    (rf_a)
   );

   reg_file_32x64 #(.N(N), .ZERO_REG(XZR_IDX), .BYPASS(1'b0)) dut_nb (
      .clk   (clk),
      .reset (reset),
      .rf    (rf_b)
   );

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rw, input logic [4:0] wreg, input logic [63:0] wdata,
                        input logic fw, input logic [3:0] fin,
                        input logic [4:0] r1, input logic [4:0] r2);
      rf_a.RegWrite = rw;  rf_b.RegWrite = rw;
      rf_a.WriteReg = wreg; rf_b.WriteReg = wreg;
      rf_a.WriteData = wdata; rf_b.WriteData = wdata;
      rf_a.FlagWrite = fw; rf_b.FlagWrite = fw;
      rf_a.FlagsIn = fin;  rf_b.FlagsIn = fin;
      rf_a.ReadReg1 = r1;  rf_b.ReadReg1 = r1;
      rf_a.ReadReg2 = r2;  rf_b.ReadReg2 = r2;
   endtask

   task automatic expect_rd(input string name, input logic [63:0] e1a, input logic [63:0] e2a,
                            input logic [63:0] e1b, input logic [63:0] e2b);
      exp_q.push_back('{name: {name, ".rd1"},    sel: SEL_RD1_A, exp: e1a});
      exp_q.push_back('{name: {name, ".rd2"},    sel: SEL_RD2_A, exp: e2a});
      exp_q.push_back('{name: {name, ".rd1_nb"}, sel: SEL_RD1_B, exp: e1b});
      exp_q.push_back('{name: {name, ".rd2_nb"}, sel: SEL_RD2_B, exp: e2b});
   endtask

   task automatic expect_fl(input string name, input logic [3:0] f);
      exp_q.push_back('{name: {name, ".flags"},    sel: SEL_FL_A, exp: {60'd0, f}});
      exp_q.push_back('{name: {name, ".flags_nb"}, sel: SEL_FL_B, exp: {60'd0, f}});
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t        e;
         logic [63:0] act;
         e = exp_q.pop_front();
         case (e.sel)
            SEL_RD1_A: act = rf_a.ReadData1;
            SEL_RD2_A: act = rf_a.ReadData2;
            SEL_FL_A:  act = {60'd0, rf_a.FlagsOut};
            SEL_RD1_B: act = rf_b.ReadData1;
            SEL_RD2_B: act = rf_b.ReadData2;
            default:   act = {60'd0, rf_b.FlagsOut};
         endcase
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed vectors ----------------
   localparam logic [63:0] X5_VAL = 64'h5555_0000_AAAA_0001;
   localparam logic [63:0] X3_VAL = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] X4_VAL = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] STEP   = 64'h0101_0101_0101_0101;

   initial begin
      reset = 1'b1;
      drive(1'b0, 5'd0, 64'd0, 1'b0, 4'b0000, 5'd0, 5'd0);
      cycle();
      cycle();

      // Populate a few entries and the flags before a mid-operation reset.
      reset = 1'b0;
      drive(1'b1, 5'd1, 64'h11, 1'b0, 4'b0000, 5'd0, 5'd0); cycle();
      drive(1'b1, 5'd2, 64'h22, 1'b0, 4'b0000, 5'd0, 5'd0); cycle();
      drive(1'b1, 5'd5, X5_VAL, 1'b0, 4'b0000, 5'd0, 5'd0); cycle();
      drive(1'b1, 5'd6, 64'h66, 1'b1, 4'b1111, 5'd0, 5'd0); cycle();

      // Reset with a coinciding write: no forwarding, stored value visible.
      reset = 1'b1;
      drive(1'b1, 5'd5, 64'hDEAD, 1'b1, 4'b0110, 5'd5, 5'd6);
      expect_rd("reset_nobypass", X5_VAL, 64'h66, X5_VAL, 64'h66);
      expect_fl("pre_reset", 4'b1111);
      cycle();

      reset = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         drive(1'b0, 5'd0, 64'd0, 1'b0, 4'b0000, 5'(i), 5'(NUM_REGS - 1 - i));
         expect_rd($sformatf("reset_clear[%0d]", i), 64'd0, 64'd0, 64'd0, 64'd0);
         if (i == 0) expect_fl("reset_clear", 4'b0000);
         cycle();
      end

      // Basic write / read, plus forwarding of the X4 write on port 2.
      drive(1'b1, 5'd3, X3_VAL, 1'b0, 4'b0000, 5'd0, 5'd0); cycle();
      drive(1'b1, 5'd4, X4_VAL, 1'b0, 4'b0000, 5'd3, 5'd4);
      expect_rd("basic_wr_x4", X3_VAL, X4_VAL, X3_VAL, 64'd0);
      cycle();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 4'b0000, 5'd3, 5'd4);
      expect_rd("basic_rd", X3_VAL, X4_VAL, X3_VAL, X4_VAL);
      cycle();

      // XZR: write discarded, always reads zero.
      drive(1'b1, 5'd31, 64'h1, 1'b0, 4'b0000, 5'd31, 5'd3);
      expect_rd("xzr_wr", 64'd0, X3_VAL, 64'd0, X3_VAL);
      cycle();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 4'b0000, 5'd31, 5'd4);
      expect_rd("xzr_after", 64'd0, X4_VAL, 64'd0, X4_VAL);
      cycle();

      // Bypass on both ports to the same register.
      drive(1'b1, 5'd7, 64'hAA, 1'b0, 4'b0000, 5'd0, 5'd0); cycle();
      drive(1'b1, 5'd7, 64'h55, 1'b0, 4'b0000, 5'd7, 5'd7);
      expect_rd("bypass_same", 64'h55, 64'h55, 64'hAA, 64'hAA);
      cycle();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 4'b0000, 5'd7, 5'd7);
      expect_rd("bypass_after", 64'h55, 64'h55, 64'h55, 64'h55);
      cycle();

      // Flags: registered, one cycle of latency, hold when not enabled.
      drive(1'b0, 5'd0, 64'd0, 1'b1, 4'b1010, 5'd0, 5'd0);
      expect_fl("flags_before", 4'b0000);
      cycle();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 4'b0101, 5'd0, 5'd0);
      expect_fl("flags_update", 4'b1010);
      cycle();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 4'b0000, 5'd0, 5'd0);
      expect_fl("flags_hold", 4'b1010);
      cycle();
      drive(1'b1, 5'd9, 64'h99, 1'b1, 4'b0101, 5'd0, 5'd0);
      expect_fl("flags_coincide_before", 4'b1010);
      cycle();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 4'b0000, 5'd9, 5'd7);
      expect_rd("coincide_x9", 64'h99, 64'h55, 64'h99, 64'h55);
      expect_fl("flags_coincide", 4'b0101);
      cycle();

      // Sweep all architectural registers.
      for (int i = 0; i < XZR_IDX; i++) begin
         drive(1'b1, 5'(i), 64'(i) * STEP, 1'b0, 4'b0000, 5'd0, 5'd0);
         cycle();
      end
      for (int i = 0; i < XZR_IDX; i++) begin
         drive(1'b0, 5'd0, 64'd0, 1'b0, 4'b0000, 5'(i), 5'(30 - i));
         expect_rd($sformatf("sweep[%0d]", i), 64'(i) * STEP, 64'(30 - i) * STEP,
                   64'(i) * STEP, 64'(30 - i) * STEP);
         cycle();
      end
      drive(1'b0, 5'd0, 64'd0, 1'b0, 4'b0000, 5'd31, 5'd31);
      expect_rd("sweep_xzr", 64'd0, 64'd0, 64'd0, 64'd0);
      cycle();

      // Let the monitor drain the last vector.
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
